// File: rtl/dice_roll_controller.sv
// dice_roll_controller: arbitrates six die buttons, spins BCD digits, decelerates and holds the result
module dice_roll_controller #(
    parameter int SLOW_STEPS   = 12,
    parameter int SHOW_TIMEOUT = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] btn_in,
    output logic [3:0] digit10,
    output logic [3:0] digit1,
    output logic [5:0] die_sel,
    output logic       rolling,
    output logic       result_valid,
    output logic       done_pulse
);
    localparam int KW = SLOW_STEPS > 1 ? $clog2(SLOW_STEPS) : 1;
    localparam int TW = SHOW_TIMEOUT > 0 ? $clog2(SHOW_TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, SPIN, SLOW, SHOW} state_t;

    state_t                r_state, w_state;
    logic [3:0]            r_d10, r_d1, w_d10, w_d1;
    logic [5:0]            r_die, w_die, r_btn_prev, w_grant;
    logic [KW-1:0]         r_k, w_k;
    logic [SLOW_STEPS-1:0] r_wait, w_wait, w_lim;
    logic [TW-1:0]         r_tmr, w_tmr;
    logic                  r_rolling, r_valid, r_done, w_done;
    logic                  w_start, w_held, w_at_max, w_last, w_timeout;
    logic [7:0]            w_max_bcd;
    logic [3:0]            w_inc_d10, w_inc_d1;

    // Only a rising edge of "any button" starts a roll; a held button after reset does nothing.
    assign w_start   = (|btn_in) & ~(|r_btn_prev);
    assign w_grant   = btn_in & (~btn_in + 6'd1);
    assign w_held    = |(btn_in & r_die);
    assign w_max_bcd = r_die[0] ? 8'h04 : r_die[1] ? 8'h06 : r_die[2] ? 8'h08 :
                       r_die[3] ? 8'h10 : r_die[4] ? 8'h20 : 8'h00;
    // 100 is displayed as 00, so 99 rolls over to 00 and 00 is the d100 maximum.
    assign w_at_max  = {r_d10, r_d1} == w_max_bcd;
    assign w_inc_d1  = w_at_max ? 4'd1 : (r_d1 == 4'd9 ? 4'd0 : r_d1 + 4'd1);
    assign w_inc_d10 = w_at_max ? 4'd0 :
                       (r_d1 == 4'd9 ? (r_d10 == 4'd9 ? 4'd0 : r_d10 + 4'd1) : r_d10);
    assign w_lim     = (SLOW_STEPS'(1) << r_k) - SLOW_STEPS'(1);
    assign w_last    = r_k == KW'(SLOW_STEPS - 1);
    assign w_timeout = (SHOW_TIMEOUT > 0) && (r_tmr == TW'(SHOW_TIMEOUT - 1));

    // Next-state and next-register logic for the roll sequencer.
    always_comb begin
        w_state = r_state;
        w_d10   = r_d10;
        w_d1    = r_d1;
        w_die   = r_die;
        w_k     = r_k;
        w_wait  = r_wait;
        w_tmr   = '0;
        w_done  = 1'b0;
        case (r_state)
            IDLE, SHOW: begin
                if (w_start) begin
                    w_state = SPIN;
                    w_d10   = 4'd0;
                    w_d1    = 4'd1;
                    w_die   = w_grant;
                    w_k     = '0;
                    w_wait  = '0;
                end else if (r_state == SHOW && w_timeout) begin
                    w_state = IDLE;
                    w_d10   = 4'd0;
                    w_d1    = 4'd0;
                    w_die   = 6'd0;
                end else if (r_state == SHOW) begin
                    w_tmr = r_tmr + TW'(1);
                end
            end
            SPIN: begin
                if (w_held) begin
                    w_d10 = w_inc_d10;
                    w_d1  = w_inc_d1;
                end else begin
                    w_state = SLOW;
                    w_k     = '0;
                    w_wait  = '0;
                end
            end
            SLOW: begin
                if (r_wait == w_lim) begin
                    w_d10  = w_inc_d10;
                    w_d1   = w_inc_d1;
                    w_wait = '0;
                    w_k    = r_k + KW'(1);
                    if (w_last) begin
                        w_state = SHOW;
                        w_done  = 1'b1;
                        w_k     = '0;
                    end
                end else begin
                    w_wait = r_wait + SLOW_STEPS'(1);
                end
            end
            default: w_state = IDLE;
        endcase
    end

    // State and output registers; flags are derived from the next state so they are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_d10      <= 4'd0;
            r_d1       <= 4'd0;
            r_die      <= 6'd0;
            r_k        <= '0;
            r_wait     <= '0;
            r_tmr      <= '0;
            r_btn_prev <= '1;
            r_rolling  <= 1'b0;
            r_valid    <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_d10      <= w_d10;
            r_d1       <= w_d1;
            r_die      <= w_die;
            r_k        <= w_k;
            r_wait     <= w_wait;
            r_tmr      <= w_tmr;
            r_btn_prev <= btn_in;
            r_rolling  <= (w_state == SPIN) || (w_state == SLOW);
            r_valid    <= w_state == SHOW;
            r_done     <= w_done;
        end
    end

    assign digit10      = r_d10;
    assign digit1       = r_d1;
    assign die_sel      = r_die;
    assign rolling      = r_rolling;
    assign result_valid = r_valid;
    assign done_pulse   = r_done;
endmodule

// File: tb/tb_dice_roll_controller.sv
// tb_dice_roll_controller: directed checks of arbitration, spin, spin-down, show timeout and reset
module tb_dice_roll_controller;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [5:0] btn_in = 6'd0;
    logic [3:0] digit10, digit1;
    logic [5:0] die_sel;
    logic       rolling, result_valid, done_pulse;
    int         errs = 0;
    int         checks = 0;
    int         v;

    dice_roll_controller #(.SLOW_STEPS(12), .SHOW_TIMEOUT(50)) dut (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_in),
        .digit10(digit10), .digit1(digit1), .die_sel(die_sel),
        .rolling(rolling), .result_valid(result_valid), .done_pulse(done_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errs++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int bcd(input int x);
        return x == 100 ? 0 : (x / 10) * 16 + x % 10;
    endfunction

    function automatic int nxt(input int x, input int n);
        return x == n ? 1 : x + 1;
    endfunction

    // Press b from IDLE/SHOW, hold for 'hold' edges checking every spin value, then release.
    task automatic spin(input logic [5:0] b, input int n, input int hold, input string tag, output int val);
        val = 1;
        btn_in = b;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (i == 0) begin
                check({tag, "_die"}, die_sel, b & (~b + 6'd1));
                check({tag, "_rolling"}, rolling, 1);
                check({tag, "_valid"}, result_valid, 0);
            end
            check({tag, "_spin"}, {digit10, digit1}, bcd(val));
            if (i < hold - 1) val = nxt(val, n);
        end
        btn_in = 6'd0;
    endtask

    // Spin-down: 12 steps totalling 4095 cycles after the SLOW entry edge; optional button noise.
    task automatic finish_roll(input int n, input int press_at, input string tag, inout int val);
        int cnt = 0;
        while (!done_pulse && cnt < 5000) begin
            @(negedge clk);
            cnt++;
            if (cnt == press_at) btn_in = 6'b010100;
            if (cnt == press_at + 3) btn_in = 6'd0;
        end
        check({tag, "_slow_len"}, cnt, 4096);
        for (int i = 0; i < 12; i++) val = nxt(val, n);
        check({tag, "_result"}, {digit10, digit1}, bcd(val));
        check({tag, "_valid"}, result_valid, 1);
        check({tag, "_rolling_off"}, rolling, 0);
        @(negedge clk);
        check({tag, "_done_once"}, done_pulse, 0);
        check({tag, "_hold"}, {digit10, digit1}, bcd(val));
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_digits", {digit10, digit1}, 0);
        check("rst_die", die_sel, 0);
        check("rst_flags", {rolling, result_valid, done_pulse}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        spin(6'b000001, 4, 10, "d4", v);
        finish_roll(4, -10, "d4", v);
        repeat (48) @(negedge clk);
        check("tmo_before", result_valid, 1);
        @(negedge clk);
        check("tmo_valid", result_valid, 0);
        check("tmo_digits", {digit10, digit1}, 0);
        check("tmo_die", die_sel, 0);

        spin(6'b100100, 8, 20, "d8", v);
        finish_roll(8, 5, "d8", v);

        spin(6'b010000, 20, 20, "d20", v);
        finish_roll(20, -10, "d20", v);

        spin(6'b100000, 100, 102, "d100", v);
        finish_roll(100, -10, "d100", v);

        spin(6'b001000, 10, 11, "d10", v);
        finish_roll(10, -10, "d10", v);

        btn_in = 6'b000010;
        repeat (3) @(negedge clk);
        check("pre_rst_rolling", rolling, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_digits", {digit10, digit1}, 0);
        check("arst_die", die_sel, 0);
        check("arst_rolling", rolling, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("held_no_roll", {rolling, die_sel}, 0);
        check("held_digits", {digit10, digit1}, 0);
        btn_in = 6'd0;
        repeat (2) @(negedge clk);
        btn_in = 6'b000010;
        @(negedge clk);
        check("repress_die", die_sel, 6'b000010);
        check("repress_digits", {digit10, digit1}, 1);
        btn_in = 6'd0;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
